// File: rtl/canvas_pkg.sv
// -----------------------------------------------------------------------------
// canvas_pkg
// Shared types and constants for the canvas draw scheduler:
//   draw_state_t       - scheduler FSM state encoding
//   DEF_*              - default grid geometry and colours
//   X_W / Y_W          - VGA pixel coordinate widths
//   cnt_width()        - counter width helper (never returns 0)
// -----------------------------------------------------------------------------
package canvas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAINT = 2'd1,
    ST_SKIP  = 2'd2,
    ST_CLEAR = 2'd3
  } draw_state_t;

  localparam int DEF_COLS   = 16;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_CELL_W = 10;
  localparam int DEF_CELL_H = 14;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 15;

  localparam logic [COLOUR_W-1:0] DEF_FG = 15'h7FFF;
  localparam logic [COLOUR_W-1:0] DEF_BG = 15'h0000;

  // Width able to hold 0..n-1; a one-element range still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/canvas_draw_scheduler_rect_raster.sv
// -----------------------------------------------------------------------------
// rect_raster
// Walks a rectangle one pixel per cycle, x inner / y outer.
//   clk, rst_n       - clock, asynchronous active-low reset
//   start            - one-cycle pulse; origin/extent are sampled while running
//   org_x, org_y     - top-left pixel of the rectangle (held stable by caller)
//   x_last, y_last   - width-1 and height-1 of the rectangle
//   x, y             - current pixel (registered)
//   we               - pixel write strobe (registered, continuous within a pass)
//   done             - high together with the last pixel's write strobe
// The first pixel appears the cycle after start; a pass of W*H pixels keeps
// we high for exactly W*H consecutive cycles.
// -----------------------------------------------------------------------------
module rect_raster
  import canvas_pkg::*;
#(
  parameter int CXW = 8,
  parameter int CYW = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [X_W-1:0] org_x,
  input  logic [Y_W-1:0] org_y,
  input  logic [CXW-1:0] x_last,
  input  logic [CYW-1:0] y_last,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           we,
  output logic           done
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [CXW-1:0] xc_q, xc_d;
  logic [CYW-1:0] yc_q, yc_d;
  logic           we_q, we_d;
  logic           done_q, done_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xc_d   = xc_q;
    yc_d   = yc_q;
    we_d   = we_q;
    done_d = done_q;
    if (start) begin
      x_d    = org_x;
      y_d    = org_y;
      xc_d   = '0;
      yc_d   = '0;
      we_d   = 1'b1;
      done_d = (x_last == '0) && (y_last == '0);
    end else if (we_q) begin
      if (done_q) begin
        we_d   = 1'b0;
        done_d = 1'b0;
      end else begin
        if (xc_q == x_last) begin
          xc_d = '0;
          x_d  = org_x;
          yc_d = yc_q + CYW'(1);
          y_d  = y_q + Y_W'(1);
        end else begin
          xc_d = xc_q + CXW'(1);
          x_d  = x_q + X_W'(1);
        end
        // Flag the final pixel as it is issued so the caller can leave on
        // the following edge without an idle gap.
        done_d = (xc_d == x_last) && (yc_d == y_last);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      xc_q   <= '0;
      yc_q   <= '0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xc_q   <= xc_d;
      yc_q   <= yc_d;
      we_q   <= we_d;
      done_q <= done_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign we   = we_q;
  assign done = done_q;

endmodule

// File: rtl/canvas_draw_scheduler.sv
// -----------------------------------------------------------------------------
// canvas_draw_scheduler
// Arbitrates cell paint/erase requests and canvas clears onto the single VGA
// write port and keeps the cell occupancy bitmap for the NN input buffer.
//   CLOCK, resetn            - clock, asynchronous active-low reset
//   paint_valid/ready        - request handshake (accepted when both high)
//   paint_col, paint_row     - target cell in grid coordinates
//   paint_erase              - erase request (only honoured with macro)
//   clear_req                - one-cycle pulse: clear whole canvas
//   xdraw, ydraw, colour     - pixel write address and data
//   writeEn                  - pixel write strobe
//   busy                     - not idle, or a clear is waiting
//   range_err                - pulse when an out-of-range request is dropped
//   occupancy                - bit row*COLS+col set when that cell is painted
// Build option: define CANVAS_ERASE_EN to honour paint_erase. Without it the
// port is present but ignored and every request paints FG_COLOUR.
// All outputs are registered.
// -----------------------------------------------------------------------------
module canvas_draw_scheduler
  import canvas_pkg::*;
#(
  parameter int                  COLS      = DEF_COLS,
  parameter int                  ROWS      = DEF_ROWS,
  parameter int                  CELL_W    = DEF_CELL_W,
  parameter int                  CELL_H    = DEF_CELL_H,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = DEF_FG,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = DEF_BG
) (
  input  logic                   CLOCK,
  input  logic                   resetn,
  input  logic                   paint_valid,
  output logic                   paint_ready,
  input  logic [4:0]             paint_col,
  input  logic [3:0]             paint_row,
  input  logic                   paint_erase,
  input  logic                   clear_req,
  output logic [X_W-1:0]         xdraw,
  output logic [Y_W-1:0]         ydraw,
  output logic [COLOUR_W-1:0]    colour,
  output logic                   writeEn,
  output logic                   busy,
  output logic                   range_err,
  output logic [COLS*ROWS-1:0]   occupancy
);

  localparam int CAN_W = COLS * CELL_W;
  localparam int CAN_H = ROWS * CELL_H;
  // The raster is shared, so its counters are sized for the larger (canvas)
  // pass; a cell pass always fits inside.
  localparam int CXW   = cnt_width(CAN_W);
  localparam int CYW   = cnt_width(CAN_H);
  localparam int IDX_W = cnt_width(COLS * ROWS);

  draw_state_t            state_q, state_d;
  logic                   clear_pending_q, clear_pending_d;
  logic                   start_q, start_d;
  logic [X_W-1:0]         org_x_q, org_x_d;
  logic [Y_W-1:0]         org_y_q, org_y_d;
  logic [CXW-1:0]         x_last_q, x_last_d;
  logic [CYW-1:0]         y_last_q, y_last_d;
  logic [COLOUR_W-1:0]    colour_q, colour_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   erase_q, erase_d;
  logic [COLS*ROWS-1:0]   occupancy_q, occupancy_d;
  logic                   range_err_q, range_err_d;
  logic                   paint_ready_q, paint_ready_d;
  logic                   busy_q, busy_d;

  logic                   erase_req;
  logic                   req_oor;
  logic [IDX_W-1:0]       req_idx;
  logic [X_W-1:0]         req_org_x;
  logic [Y_W-1:0]         req_org_y;
  logic                   rast_done;

`ifdef CANVAS_ERASE_EN
  assign erase_req = paint_erase;
`else
  logic unused_erase;
  assign unused_erase = paint_erase;
  assign erase_req    = 1'b0;
`endif

  assign req_oor   = (int'(paint_col) >= COLS) || (int'(paint_row) >= ROWS);
  assign req_idx   = IDX_W'(int'(paint_row) * COLS + int'(paint_col));
  assign req_org_x = X_W'(int'(paint_col) * CELL_W);
  assign req_org_y = Y_W'(int'(paint_row) * CELL_H);

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q | clear_req;
    start_d         = 1'b0;
    org_x_d         = org_x_q;
    org_y_d         = org_y_q;
    x_last_d        = x_last_q;
    y_last_d        = y_last_q;
    colour_d        = colour_q;
    idx_d           = idx_q;
    erase_d         = erase_q;
    occupancy_d     = occupancy_q;
    range_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_pending_q) begin
          state_d         = ST_CLEAR;
          start_d         = 1'b1;
          org_x_d         = '0;
          org_y_d         = '0;
          x_last_d        = CXW'(CAN_W - 1);
          y_last_d        = CYW'(CAN_H - 1);
          colour_d        = BG_COLOUR;
          occupancy_d     = '0;
          // A clear_req coinciding with entry must still re-arm.
          clear_pending_d = clear_req;
        end else if (paint_valid && paint_ready_q) begin
          if (req_oor) begin
            range_err_d = 1'b1;
          end else if (occupancy_q[req_idx] == !erase_req) begin
            state_d = ST_SKIP;
          end else begin
            state_d  = ST_PAINT;
            start_d  = 1'b1;
            org_x_d  = req_org_x;
            org_y_d  = req_org_y;
            x_last_d = CXW'(CELL_W - 1);
            y_last_d = CYW'(CELL_H - 1);
            colour_d = erase_req ? BG_COLOUR : FG_COLOUR;
            idx_d    = req_idx;
            erase_d  = erase_req;
          end
        end
      end
      ST_PAINT: begin
        if (rast_done) begin
          state_d            = ST_IDLE;
          occupancy_d[idx_q] = !erase_q;
        end
      end
      ST_SKIP: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (rast_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake/status outputs are registered from next-state values so they
    // always describe the state the FSM is actually in.
    paint_ready_d = (state_d == ST_IDLE) && !clear_pending_d;
    busy_d        = (state_d != ST_IDLE) || clear_pending_d;
  end

  always_ff @(posedge CLOCK or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      clear_pending_q <= 1'b0;
      start_q         <= 1'b0;
      org_x_q         <= '0;
      org_y_q         <= '0;
      x_last_q        <= '0;
      y_last_q        <= '0;
      colour_q        <= BG_COLOUR;
      idx_q           <= '0;
      erase_q         <= 1'b0;
      occupancy_q     <= '0;
      range_err_q     <= 1'b0;
      paint_ready_q   <= 1'b1;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      start_q         <= start_d;
      org_x_q         <= org_x_d;
      org_y_q         <= org_y_d;
      x_last_q        <= x_last_d;
      y_last_q        <= y_last_d;
      colour_q        <= colour_d;
      idx_q           <= idx_d;
      erase_q         <= erase_d;
      occupancy_q     <= occupancy_d;
      range_err_q     <= range_err_d;
      paint_ready_q   <= paint_ready_d;
      busy_q          <= busy_d;
    end
  end

  rect_raster #(
    .CXW (CXW),
    .CYW (CYW)
  ) u_raster (
    .clk    (CLOCK),
    .rst_n  (resetn),
    .start  (start_q),
    .org_x  (org_x_q),
    .org_y  (org_y_q),
    .x_last (x_last_q),
    .y_last (y_last_q),
    .x      (xdraw),
    .y      (ydraw),
    .we     (writeEn),
    .done   (rast_done)
  );

  assign colour      = colour_q;
  assign paint_ready = paint_ready_q;
  assign busy        = busy_q;
  assign range_err   = range_err_q;
  assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_canvas_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_canvas_draw_scheduler
// Directed table of paint/erase/out-of-range requests with hand-computed
// expectations, followed by a clear raised mid-paint and a reset mid-clear.
// -----------------------------------------------------------------------------
module tb_canvas_draw_scheduler;

  localparam int K_PAINT = 0;
  localparam int K_SKIP  = 1;
  localparam int K_RANGE = 2;

  logic          CLOCK = 1'b0;
  logic          resetn;
  logic          paint_valid = 1'b0;
  logic          paint_ready;
  logic [4:0]    paint_col = '0;
  logic [3:0]    paint_row = '0;
  logic          paint_erase = 1'b0;
  logic          clear_req = 1'b0;
  logic [7:0]    xdraw;
  logic [6:0]    ydraw;
  logic [14:0]   colour;
  logic          writeEn;
  logic          busy;
  logic          range_err;
  logic [127:0]  occupancy;

  always #5 CLOCK = ~CLOCK;

  canvas_draw_scheduler dut (
    .CLOCK       (CLOCK),
    .resetn      (resetn),
    .paint_valid (paint_valid),
    .paint_ready (paint_ready),
    .paint_col   (paint_col),
    .paint_row   (paint_row),
    .paint_erase (paint_erase),
    .clear_req   (clear_req),
    .xdraw       (xdraw),
    .ydraw       (ydraw),
    .colour      (colour),
    .writeEn     (writeEn),
    .busy        (busy),
    .range_err   (range_err),
    .occupancy   (occupancy)
  );

  typedef struct {
    logic [4:0] col;
    logic [3:0] row;
    logic       erase;
    int         kind;
    int         x0;
    int         y0;
    int         idx;
    logic       occ;
    logic       bg;
  } vec_t;

  vec_t         vecs [8];
  logic [127:0] exp_occ;

  int checks = 0;
  int errors = 0;

  int wr_cnt, wr_fg, wr_bg, first_k, last_k, fx, fy;
  int minx, maxx, miny, maxy, ready_k, err_cnt, busy0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_occ(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic request(input logic [4:0] c, input logic [3:0] r, input logic e);
    paint_col   = c;
    paint_row   = r;
    paint_erase = e;
    paint_valid = 1'b1;
    tick();
    paint_valid = 1'b0;
  endtask

  // Samples from the cycle after acceptance (k=0) until paint_ready is seen
  // high or max_k cycles elapse. Optionally pulses clear_req once the clr_at'th
  // write has been observed.
  task automatic collect(input int max_k, input int clr_at);
    int  k;
    bit  pulsed;
    k = 0; pulsed = 0;
    wr_cnt = 0; wr_fg = 0; wr_bg = 0; first_k = -1; last_k = -1;
    fx = -1; fy = -1; minx = 9999; maxx = -1; miny = 9999; maxy = -1;
    ready_k = -1; err_cnt = 0; busy0 = busy;
    while (ready_k < 0 && k <= max_k) begin
      if (range_err) err_cnt++;
      if (writeEn) begin
        wr_cnt++;
        if (colour == 15'h7FFF) wr_fg++;
        else if (colour == 15'h0000) wr_bg++;
        if (first_k < 0) begin first_k = k; fx = xdraw; fy = ydraw; end
        last_k = k;
        if (int'(xdraw) < minx) minx = xdraw;
        if (int'(xdraw) > maxx) maxx = xdraw;
        if (int'(ydraw) < miny) miny = ydraw;
        if (int'(ydraw) > maxy) maxy = ydraw;
      end
      if (paint_ready) begin
        ready_k = k;
      end else begin
        if (clear_req) clear_req = 1'b0;
        if (clr_at > 0 && !pulsed && wr_cnt == clr_at) begin
          clear_req = 1'b1;
          pulsed    = 1;
        end
        tick();
        k++;
      end
    end
    if (ready_k < 0) $display("FAIL timeout: paint_ready not seen within %0d cycles", max_k);
  endtask

  initial begin
    vecs[0] = '{5'd3,  4'd2, 1'b0, K_PAINT,  30, 28,  35, 1'b1, 1'b0};
    vecs[1] = '{5'd3,  4'd2, 1'b0, K_SKIP,    0,  0,  35, 1'b1, 1'b0};
    vecs[2] = '{5'd16, 4'd0, 1'b0, K_RANGE,   0,  0,  -1, 1'b0, 1'b0};
    vecs[3] = '{5'd0,  4'd9, 1'b0, K_RANGE,   0,  0,  -1, 1'b0, 1'b0};
    vecs[4] = '{5'd15, 4'd7, 1'b0, K_PAINT, 150, 98, 127, 1'b1, 1'b0};
    vecs[5] = '{5'd5,  4'd7, 1'b0, K_PAINT,  50, 98, 117, 1'b1, 1'b0};
`ifdef CANVAS_ERASE_EN
    vecs[6] = '{5'd5,  4'd7, 1'b1, K_PAINT,  50, 98, 117, 1'b0, 1'b1};
    vecs[7] = '{5'd6,  4'd7, 1'b1, K_SKIP,    0,  0, 118, 1'b0, 1'b0};
`else
    vecs[6] = '{5'd5,  4'd7, 1'b1, K_SKIP,    0,  0, 117, 1'b1, 1'b0};
    vecs[7] = '{5'd6,  4'd7, 1'b1, K_PAINT,  60, 98, 118, 1'b1, 1'b0};
`endif
    exp_occ = '0;

    // Reset state
    resetn = 1'b1;
    #2 resetn = 1'b0;
    tick();
    tick();
    chk("rst_writeEn", writeEn, 0);
    chk("rst_xdraw", xdraw, 0);
    chk("rst_ydraw", ydraw, 0);
    chk("rst_colour", colour, 15'h0000);
    chk("rst_ready", paint_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_range_err", range_err, 0);
    chk_occ("rst_occupancy", occupancy, exp_occ);
    resetn = 1'b1;
    tick();

    // Table-driven requests
    for (int i = 0; i < 8; i++) begin
      request(vecs[i].col, vecs[i].row, vecs[i].erase);
      collect(400, 0);
      if (vecs[i].kind == K_PAINT) begin
        chk($sformatf("v%0d_writes", i), wr_cnt, 140);
        chk($sformatf("v%0d_colour_writes", i), vecs[i].bg ? wr_bg : wr_fg, 140);
        chk($sformatf("v%0d_first_k", i), first_k, 1);
        chk($sformatf("v%0d_first_x", i), fx, vecs[i].x0);
        chk($sformatf("v%0d_first_y", i), fy, vecs[i].y0);
        chk($sformatf("v%0d_min_x", i), minx, vecs[i].x0);
        chk($sformatf("v%0d_max_x", i), maxx, vecs[i].x0 + 9);
        chk($sformatf("v%0d_min_y", i), miny, vecs[i].y0);
        chk($sformatf("v%0d_max_y", i), maxy, vecs[i].y0 + 13);
        chk($sformatf("v%0d_last_k", i), last_k, 140);
        chk($sformatf("v%0d_ready_k", i), ready_k, 141);
        chk($sformatf("v%0d_busy", i), busy0, 1);
        chk($sformatf("v%0d_range_err", i), err_cnt, 0);
      end else if (vecs[i].kind == K_SKIP) begin
        chk($sformatf("v%0d_writes", i), wr_cnt, 0);
        chk($sformatf("v%0d_ready_k", i), ready_k, 1);
        chk($sformatf("v%0d_busy", i), busy0, 1);
        chk($sformatf("v%0d_range_err", i), err_cnt, 0);
      end else begin
        chk($sformatf("v%0d_writes", i), wr_cnt, 0);
        chk($sformatf("v%0d_ready_k", i), ready_k, 0);
        chk($sformatf("v%0d_range_err", i), err_cnt, 1);
        chk($sformatf("v%0d_busy", i), busy0, 0);
        tick();
        chk($sformatf("v%0d_range_err_pulse", i), range_err, 0);
        chk($sformatf("v%0d_no_write", i), writeEn, 0);
      end
      if (vecs[i].idx >= 0) exp_occ[vecs[i].idx] = vecs[i].occ;
      chk_occ($sformatf("v%0d_occupancy", i), occupancy, exp_occ);
    end

    // Clear raised at the 50th pixel of a paint of (0,0)
    request(5'd0, 4'd0, 1'b0);
    collect(20000, 50);
    chk("clr_fg_writes", wr_fg, 140);
    chk("clr_bg_writes", wr_bg, 17920);
    chk("clr_total_writes", wr_cnt, 18060);
    chk("clr_first_k", first_k, 1);
    chk("clr_last_k", last_k, 18062);
    chk("clr_ready_k", ready_k, 18063);
    chk("clr_min_x", minx, 0);
    chk("clr_max_x", maxx, 159);
    chk("clr_max_y", maxy, 111);
    exp_occ = '0;
    chk_occ("clr_occupancy", occupancy, exp_occ);
    chk("clr_busy_after", busy, 0);

    // Reset asserted in the middle of a clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (300) tick();
    chk("mid_clear_writeEn", writeEn, 1);
    chk("mid_clear_ready", paint_ready, 0);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_writeEn", writeEn, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", paint_ready, 1);
    chk("async_rst_xdraw", xdraw, 0);
    tick();
    resetn = 1'b1;
    wr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (writeEn) wr_cnt++;
    end
    chk("post_rst_writes", wr_cnt, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", paint_ready, 1);
    chk_occ("post_rst_occupancy", occupancy, exp_occ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/canvas_draw_scheduler.md
# canvas_draw_scheduler

Sequencer and arbiter for the VGA canvas write port in the handwriting-input front end. It accepts cell-paint requests (grid coordinates from the mouse snapping logic) and a canvas-clear request, and rasterises each into one-pixel-per-cycle writes for the VGA adapter. It also maintains the cell occupancy bitmap that feeds the neural-network input buffer.

## Interface
- `COLS`, 16: grid columns.
- `ROWS`, 8: grid rows.
- `CELL_W`, 10: cell width in pixels.
- `CELL_H`, 14: cell height in pixels.
- `FG_COLOUR`, 15'h7FFF: paint colour.
- `BG_COLOUR`, 15'h0000: clear/erase colour.

Ports:
- `CLOCK` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `paint_valid` in 1: paint request pending.
- `paint_ready` out 1: request accepted when both valid and ready are high on an edge.
- `paint_col` in 5: cell column.
- `paint_row` in 4: cell row.
- `paint_erase` in 1: erase instead of paint (only with macro).
- `clear_req` in 1: single-cycle pulse requesting a full canvas clear.
- `xdraw` out 8: pixel x.
- `ydraw` out 7: pixel y.
- `colour` out 15: pixel colour.
- `writeEn` out 1: pixel write strobe.
- `busy` out 1: state is not IDLE, or a clear is pending.
- `range_err` out 1: one-cycle pulse when an out-of-range request is dropped.
- `occupancy` out COLS*ROWS: bit `row*COLS+col` is set when that cell is painted.

## Operation
- States: IDLE, PAINT, SKIP, CLEAR.
- IDLE:
  - If `clear_pending`, go to CLEAR.
  - Otherwise, on a paint handshake:
    - Out-of-range request (col ≥ COLS or row ≥ ROWS): drop it and pulse `range_err`.
    - Target cell already in the requested state (painted for paint, empty for erase): go to SKIP.
    - Otherwise: go to PAINT.
- `paint_ready` = IDLE && !`clear_pending`.
- PAINT:
  - Latch the origin (col*CELL_W, row*CELL_H) and colour at acceptance.
  - Raster x inner, y outer, CELL_W*CELL_H writes.
  - On the last pixel, update the occupancy bit (set for paint, clear for erase), then go to IDLE.
- SKIP: no writes for one cycle, then go to IDLE.
- CLEAR:
  - Raster (0,0) to (COLS*CELL_W-1, ROWS*CELL_H-1) in BG_COLOUR.
  - `occupancy` is zeroed on entry.
  - `clear_pending` is dropped on entry.
  - Go to IDLE after the last pixel.
- `clear_req` sets `clear_pending` in any state. Clear has priority over paint.
- A clear arriving mid-PAINT does not abort the cell; it runs after the cell completes.
- A `clear_req` during CLEAR re-arms `clear_pending`, so a second clear follows.
- Arithmetic:
  - Origin multiply is by constant parameters, width-extended to 8/7 bits.
  - Pixel counters are sized by `$clog2` of CELL_W, CELL_H, COLS*CELL_W and ROWS*CELL_H; no wrap occurs inside a pass.
- Reset mid-operation aborts immediately: all state and outputs return to reset values and the pending clear is lost.

## Timing
- Reset values:
  - `writeEn`, `xdraw`, `ydraw`, `range_err`, `occupancy`: 0.
  - `colour`: BG_COLOUR.
  - `paint_ready`: 1.
  - `busy`: 0.
- All outputs are registered.
- Paint accepted at edge N: the first `writeEn` is visible after edge N+1 with the origin pixel; the last write follows edge N+140 (defaults). `paint_ready` returns high after edge N+141.
- SKIP: `paint_ready` is low for exactly one cycle after acceptance; no `writeEn`.
- Clear with defaults: 160*112 = 17920 consecutive `writeEn` cycles, starting one cycle after CLEAR is entered.
- `writeEn` is continuous (no gaps) within a pass.

## Configuration
- `CANVAS_ERASE_EN` defined:
  - `paint_erase` is honoured: an erase writes BG_COLOUR and clears the occupancy bit.
  - Erasing an empty cell goes to SKIP.
- Undefined:
  - `paint_erase` is ignored (the port stays in the interface).
  - All requests paint FG_COLOUR.

## Structure
- Package `canvas_pkg`: the state enum `draw_state_t`, default geometry constants, and FG/BG colour constants.
- Sub-module `rect_raster`:
  - Inputs: start pulse, origin, width, height.
  - Outputs: x/y, write strobe, done.
  - Instanced once and shared by PAINT and CLEAR.

## Test plan
- Reset, then paint (3,2): 140 writes covering x 30..39, y 28..41. The first write is at (30,28) one cycle after acceptance. Then `occupancy[35]`=1 and `paint_ready` rises.
- Paint (3,2) again: SKIP path, zero writes, `paint_ready` low for exactly one cycle.
- Paint (16,0): `range_err` pulses, no writes, occupancy unchanged.
- `clear_req` at the 50th pixel of a paint of (0,0):
  - The cell completes all 140 writes.
  - Then CLEAR performs 17920 BG writes.
  - `occupancy` reads 0; `paint_ready` is low throughout.
- With `CANVAS_ERASE_EN`, erase a painted (5,7): 140 BG_COLOUR writes and `occupancy[117]`=0. Without the macro, the same stimulus paints FG.
- Assert `resetn` low mid-clear: `writeEn` drops to 0 immediately (asynchronous), and after release `busy`=0 and `paint_ready`=1.
